sensor_conditioner: RTL
=======================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameters SHALL be exactly: DEBOUNCE, default 4, cycles a detector must stay high before presence is declared (legal 2..255); HOLD, default 8, gap-extension cycles after the detector releases (legal 1..255); CNT_W, default 8, vehicle counter width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be exactly:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous active-low reset
- raw_a  in  1  asynchronous loop-detector input, road A
- raw_b  in  1  asynchronous loop-detector input, road B
- count_clr  in  1  synchronous clear of both vehicle counters
- ta  out  1  conditioned traffic presence, road A (feeds the traffic light FSM)
- tb  out  1  conditioned traffic presence, road B
- cnt_a  out  CNT_W  vehicles detected on road A, saturating
- cnt_b  out  CNT_W  vehicles detected on road B, saturating

Function
REQ-004 Each raw input SHALL pass through a 2-flop synchronizer; "s" below is the second flop's output.
REQ-005 Each lane SHALL run an independent 4-state Moore FSM: IDLE, ARMING, PRESENT, HOLD; a lane has an 8-bit timer tmr.
REQ-006 IDLE: s=1 -> ARMING, tmr<=1; else stay.
REQ-007 ARMING: s=0 -> IDLE; s=1 and tmr==DEBOUNCE-1 -> PRESENT; else tmr<=tmr+1.
REQ-008 PRESENT: s=0 -> HOLD, tmr<=1; else stay.
REQ-009 HOLD: s=1 -> PRESENT; s=0 and tmr==HOLD -> IDLE; else tmr<=tmr+1.
REQ-010 ta/tb SHALL be 1 exactly when the lane state is PRESENT or HOLD, decoded from registered state (no combinational path from raw inputs).
REQ-011 With raw held high from first sampling edge E1, ta SHALL rise after edge E1+DEBOUNCE+1 (DEBOUNCE+2 edges inclusive).
REQ-012 With raw held low from sampling edge E1 while PRESENT, ta SHALL fall after edge E1+HOLD+2.
REQ-013 A raw high pulse shorter than DEBOUNCE synchronized cycles SHALL NOT assert ta nor change the counter.
REQ-014 A raw low gap of HOLD synchronized cycles or fewer SHALL keep ta continuously high.
REQ-015 The counter SHALL increment by 1 on each ARMING->PRESENT transition only; HOLD->PRESENT SHALL NOT count.
REQ-016 The counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 count_clr=1 SHALL load 0 on the next edge; if an increment occurs in the same cycle, the counter SHALL load 1.
REQ-018 Lanes SHALL be fully independent; simultaneous events on both lanes SHALL be handled in the same cycle.

Reset
REQ-019 reset=0 SHALL asynchronously force: synchronizer flops 0, state IDLE, tmr 0, ta=0, tb=0, cnt_a=0, cnt_b=0.
REQ-020 Reset asserted mid-PRESENT or mid-HOLD SHALL drop ta/tb immediately without waiting for a clock.
REQ-021 After reset release, a raw input already high SHALL be treated as a new arrival (full debounce, counted once).

Structure
REQ-022 A shared package SHALL hold the lane state enum (IDLE, ARMING, PRESENT, HOLD) and the default DEBOUNCE, HOLD, CNT_W constants.
REQ-023 One sub-module, sensor_lane (synchronizer, FSM, timer, counter), SHALL be instantiated twice, once per road.

Verification
REQ-024 Reset, raw_a=1 held from sampling edge E1 -> ta=0 through edge E1+4, ta=1 after edge E1+5, cnt_a=1; tb=0, cnt_b=0 throughout.
REQ-025 raw_b 3-cycle high pulse -> tb stays 0, cnt_b stays 0.
REQ-026 raw_a in PRESENT, drops low 5 cycles then high -> ta never falls, cnt_a unchanged; then low held -> ta falls after edge E1+10 relative to the low sampling edge.
REQ-027 CNT_W=8, 256 debounced arrivals on road A -> cnt_a=255; count_clr pulse -> cnt_a=0; clr coincident with arrival -> cnt_a=1.
REQ-028 Both raw inputs high same cycle -> ta and tb rise same edge; reset asserted mid-HOLD -> ta=tb=0 immediately, counters 0.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
// Shared types and default timing constants for the loop-detector conditioner.
package sensor_conditioner_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE = 4;
  localparam int unsigned DEFAULT_HOLD     = 8;
  localparam int unsigned DEFAULT_CNT_W    = 8;
  localparam int unsigned TMR_W            = 8;

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'd0,
    LANE_ARMING  = 2'd1,
    LANE_PRESENT = 2'd2,
    LANE_HOLD    = 2'd3
  } lane_state_e;

endpackage

// File: rtl/sensor_lane.sv
// One road: synchronizer, debounce/hold FSM with timer, saturating arrival counter.
module sensor_lane
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
  parameter int unsigned HOLD     = DEFAULT_HOLD,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  input  logic             count_clr,
  output logic             present,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync_q1;
  logic             sync_q2;
  lane_state_e      state_q;
  lane_state_e      state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             present_d;
  logic [CNT_W-1:0] cnt_d;
  logic             arrive_c;

  // Two-flop synchronizer for the asynchronous detector input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_IDLE;
      tmr_q   <= '0;
      present <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      present <= present_d;
      cnt     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LANE_IDLE:    if (sync_q2) state_d = LANE_ARMING;
      LANE_ARMING:  if (!sync_q2) state_d = LANE_IDLE;
                    else if (tmr_q == DEB_LAST) state_d = LANE_PRESENT;
      LANE_PRESENT: if (!sync_q2) state_d = LANE_HOLD;
      LANE_HOLD:    if (sync_q2) state_d = LANE_PRESENT;
                    else if (tmr_q == HOLD_LAST) state_d = LANE_IDLE;
      default:      state_d = LANE_IDLE;
    endcase
  end

  // Timer, presence and counter updates; only a debounced arrival counts.
  always_comb begin
    tmr_d     = tmr_q;
    present_d = (state_d == LANE_PRESENT) || (state_d == LANE_HOLD);
    arrive_c  = (state_q == LANE_ARMING) && (state_d == LANE_PRESENT);
    cnt_d     = cnt;
    unique case (state_q)
      LANE_IDLE:    if (sync_q2) tmr_d = TMR_W'(1);
      LANE_ARMING:  if (state_d == LANE_ARMING) tmr_d = tmr_q + TMR_W'(1);
      LANE_PRESENT: if (!sync_q2) tmr_d = TMR_W'(1);
      LANE_HOLD:    if (state_d == LANE_HOLD) tmr_d = tmr_q + TMR_W'(1);
      default:      tmr_d = '0;
    endcase
    if (count_clr) begin
      cnt_d = arrive_c ? CNT_W'(1) : '0;
    end else if (arrive_c && (cnt != CNT_MAX)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Two-road loop-detector conditioner feeding the traffic light controller.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
  parameter int unsigned HOLD     = DEFAULT_HOLD,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             count_clr,
  output logic             ta,
  output logic             tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  sensor_lane #(.DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .CNT_W(CNT_W)) u_lane_a (
    .clk       (clk),
    .rst_n     (reset),
    .raw       (raw_a),
    .count_clr (count_clr),
    .present   (ta),
    .cnt       (cnt_a)
  );

  sensor_lane #(.DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .CNT_W(CNT_W)) u_lane_b (
    .clk       (clk),
    .rst_n     (reset),
    .raw       (raw_b),
    .count_clr (count_clr),
    .present   (tb),
    .cnt       (cnt_b)
  );

endmodule
